// File: rtl/icache_mem_ctrl_pkg.sv
// Shared types for the I-cache miss controller: bus command encoding,
// MSHR entry state and the MSHR entry record.
package icache_mem_ctrl_pkg;
  localparam int XLEN  = 32;
  localparam int BLK_W = XLEN - 3;   // 8-byte blocks

  typedef enum logic [1:0] {BUS_NONE, BUS_LOAD, BUS_STORE} BUS_COMMAND;
  typedef enum logic [1:0] {EMPTY, WAIT_ISSUE, WAIT_DATA} MSHR_STATE;

  typedef struct packed {
    MSHR_STATE        state;
    logic [BLK_W-1:0] block_addr;
    logic [3:0]       mem_tag;
  } ICACHE_MSHR_ENTRY;
endpackage

// File: rtl/icache_issue_fifo.sv
// Circular FIFO of MSHR indices kept in allocation order.
// Ports: push/push_idx enqueue, pop dequeues head_idx, flush empties,
// empty/full status.
module icache_issue_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [$clog2(DEPTH)-1:0] push_idx,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH)-1:0] head_idx,
  output logic                     empty,
  output logic                     full
);
  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0][IW-1:0] mem;
  logic [IW-1:0]            rd_ptr, wr_ptr;
  logic [IW:0]              cnt;

  assign head_idx = mem[rd_ptr];
  assign empty    = (cnt == '0);
  assign full     = (cnt == (IW+1)'(DEPTH));

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{IW{1'b0}}, push} - {{IW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_idx;
  end
endmodule

// File: rtl/icache_mem_ctrl.sv
// I-cache miss handler and memory-port arbiter.
// Ports: fetch_addr/fetch_miss per fetch slot (slot 2 oldest), take_branch
// squash; dcache_* D-side request in, dcache_response back; proc2mem_*
// muxed memory request, mem2proc_* memory response/return; fill_valid/
// fill_addr I-cache fill; slot_pending, miss_stall status to fetch.
module icache_mem_ctrl
  import icache_mem_ctrl_pkg::*;
#(
  parameter int MSHR_DEPTH   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0][XLEN-1:0] fetch_addr,
  input  logic [2:0]           fetch_miss,
  input  logic                 take_branch,
  input  BUS_COMMAND           dcache_command,
  input  logic [XLEN-1:0]      dcache_addr,
  input  logic [63:0]          dcache_data,
  output logic [3:0]           dcache_response,
  input  logic [3:0]           mem2proc_response,
  input  logic [63:0]          mem2proc_data,
  input  logic [3:0]           mem2proc_tag,
  output BUS_COMMAND           proc2mem_command,
  output logic [XLEN-1:0]      proc2mem_addr,
  output logic [63:0]          proc2mem_data,
  output logic                 fill_valid,
  output logic [XLEN-1:0]      fill_addr,
  output logic [2:0]           slot_pending,
  output logic                 miss_stall
);
  localparam int IW = $clog2(MSHR_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  ICACHE_MSHR_ENTRY [MSHR_DEPTH-1:0] mshr, mshr_nxt;
  logic [SW-1:0] starve_cnt;

  logic [2:0]    slot_hit;
  logic          cand_vld, free_vld, fill_hit, alloc;
  logic [1:0]    cand_slot;
  logic [IW-1:0] free_idx, fill_idx, head_idx;
  logic          fifo_empty, fifo_full;
  logic          i_req, starved, i_grant, accept;

  // Per-slot block match against live entries, allocation candidate
  // (highest-index unmatched miss), lowest free entry, and fill lookup.
  always_comb begin
    slot_hit  = '0;
    cand_vld  = 1'b0;
    cand_slot = '0;
    free_vld  = 1'b0;
    free_idx  = '0;
    fill_hit  = 1'b0;
    fill_idx  = '0;
    for (int s = 0; s < 3; s++) begin
      for (int e = 0; e < MSHR_DEPTH; e++)
        if (mshr[e].state != EMPTY && mshr[e].block_addr == fetch_addr[s][XLEN-1:3])
          slot_hit[s] = 1'b1;
      if (fetch_miss[s] && !slot_hit[s]) begin
        cand_vld  = 1'b1;
        cand_slot = 2'(s);
      end
    end
    for (int e = MSHR_DEPTH-1; e >= 0; e--) begin
      if (mshr[e].state == EMPTY) begin
        free_vld = 1'b1;
        free_idx = IW'(e);
      end
      if (mshr[e].state == WAIT_DATA && mem2proc_tag != 4'd0 &&
          mshr[e].mem_tag == mem2proc_tag) begin
        fill_hit = 1'b1;
        fill_idx = IW'(e);
      end
    end
  end

  assign slot_pending = fetch_miss & slot_hit;
  assign miss_stall   = !free_vld;
  assign alloc        = cand_vld && free_vld && !take_branch;
  assign fill_valid   = fill_hit;
  assign fill_addr    = {mshr[fill_idx].block_addr, 3'b000};

  // D-side owns the port unless idle or the I-side has starved long enough.
  assign i_req   = !fifo_empty;
  assign starved = (starve_cnt == SW'(STARVE_LIMIT));
  assign i_grant = i_req && (dcache_command == BUS_NONE || starved);
  assign accept  = i_grant && (mem2proc_response != 4'd0);

  always_comb begin
    if (i_grant) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = {mshr[head_idx].block_addr, 3'b000};
      proc2mem_data    = '0;
      dcache_response  = 4'd0;
    end else begin
      proc2mem_command = dcache_command;
      proc2mem_addr    = dcache_addr;
      proc2mem_data    = dcache_data;
      dcache_response  = mem2proc_response;
    end
  end

  // Entry transitions. Accept is applied after the squash so an issue
  // accepted alongside a branch still lands in WAIT_DATA.
  always_comb begin
    mshr_nxt = mshr;
    if (fill_hit) mshr_nxt[fill_idx].state = EMPTY;
    if (take_branch)
      for (int e = 0; e < MSHR_DEPTH; e++)
        if (mshr[e].state == WAIT_ISSUE) mshr_nxt[e].state = EMPTY;
    if (accept) begin
      mshr_nxt[head_idx].state   = WAIT_DATA;
      mshr_nxt[head_idx].mem_tag = mem2proc_response;
    end
    if (alloc) begin
      mshr_nxt[free_idx].state      = WAIT_ISSUE;
      mshr_nxt[free_idx].block_addr = fetch_addr[cand_slot][XLEN-1:3];
      mshr_nxt[free_idx].mem_tag    = 4'd0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mshr       <= '0;
      starve_cnt <= '0;
    end else begin
      mshr <= mshr_nxt;
      if (!i_req || i_grant) starve_cnt <= '0;
      else if (!starved)     starve_cnt <= starve_cnt + 1'b1;
    end
  end

  icache_issue_fifo #(.DEPTH(MSHR_DEPTH)) u_issue_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (alloc),
    .push_idx (free_idx),
    .pop      (accept),
    .flush    (take_branch),
    .head_idx (head_idx),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  logic unused_ok;
  assign unused_ok = ^{fifo_full, mem2proc_data};
endmodule

// File: tb/tb_icache_mem_ctrl.sv
module tb_icache_mem_ctrl;
  import icache_mem_ctrl_pkg::*;

  localparam int DEPTH  = 4;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0][31:0] fetch_addr;
  logic [2:0]       fetch_miss;
  logic             take_branch;
  BUS_COMMAND       dcache_command, proc2mem_command;
  logic [31:0]      dcache_addr, proc2mem_addr, fill_addr;
  logic [63:0]      dcache_data, mem2proc_data, proc2mem_data;
  logic [3:0]       dcache_response, mem2proc_response, mem2proc_tag;
  logic             fill_valid, miss_stall;
  logic [2:0]       slot_pending;

  icache_mem_ctrl #(.MSHR_DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .clock(clk), .reset(rst),
    .fetch_addr(fetch_addr), .fetch_miss(fetch_miss), .take_branch(take_branch),
    .dcache_command(dcache_command), .dcache_addr(dcache_addr), .dcache_data(dcache_data),
    .dcache_response(dcache_response),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr),
    .slot_pending(slot_pending), .miss_stall(miss_stall)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an outstanding-miss table (0 free, 1 awaiting issue,
  // 2 awaiting data), a queue of entries in issue order, starvation count.
  int          st[DEPTH];
  logic [28:0] blk[DEPTH];
  logic [3:0]  tg[DEPTH];
  int          q[$];
  int          starve;

  BUS_COMMAND  m_cmd;
  logic [31:0] m_addr, m_faddr;
  logic [63:0] m_pdata;
  logic [3:0]  m_dresp;
  logic [2:0]  m_pend;
  logic        m_fill, m_stall, m_grant;
  int          m_fe;

  function automatic bit tracked(input logic [31:0] a);
    for (int e = 0; e < DEPTH; e++)
      if (st[e] != 0 && blk[e] == a[31:3]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_clear();
    for (int e = 0; e < DEPTH; e++) begin st[e] = 0; blk[e] = '0; tg[e] = '0; end
    q.delete();
    starve = 0;
  endfunction

  function automatic void model_eval();
    m_pend  = '0;
    m_stall = 1'b1;
    for (int s = 0; s < 3; s++) m_pend[s] = fetch_miss[s] && tracked(fetch_addr[s]);
    for (int e = 0; e < DEPTH; e++) if (st[e] == 0) m_stall = 1'b0;
    m_grant = (q.size() != 0) && (dcache_command == BUS_NONE || starve == STARVE);
    if (m_grant) begin
      m_cmd = BUS_LOAD; m_addr = {blk[q[0]], 3'b000}; m_pdata = '0; m_dresp = '0;
    end else begin
      m_cmd = dcache_command; m_addr = dcache_addr; m_pdata = dcache_data; m_dresp = mem2proc_response;
    end
    m_fill = 1'b0; m_faddr = '0; m_fe = -1;
    for (int e = 0; e < DEPTH; e++)
      if (!m_fill && st[e] == 2 && mem2proc_tag != 0 && tg[e] == mem2proc_tag) begin
        m_fill = 1'b1; m_faddr = {blk[e], 3'b000}; m_fe = e;
      end
  endfunction

  function automatic void model_update();
    int cand = -1;
    int free = -1;
    bit had_req = (q.size() != 0);
    for (int s = 0; s < 3; s++)
      if (fetch_miss[s] && !tracked(fetch_addr[s])) cand = s;
    for (int e = DEPTH-1; e >= 0; e--) if (st[e] == 0) free = e;
    if (m_grant && mem2proc_response != 0) begin
      int e = q.pop_front();
      st[e] = 2; tg[e] = mem2proc_response;
    end
    if (m_fe >= 0) st[m_fe] = 0;
    starve = (!had_req || m_grant) ? 0 : starve + 1;
    if (take_branch) begin
      for (int e = 0; e < DEPTH; e++) if (st[e] == 1) st[e] = 0;
      q.delete();
    end else if (cand >= 0 && free >= 0) begin
      st[free] = 1; blk[free] = fetch_addr[cand][31:3]; q.push_back(free);
    end
  endfunction

  task automatic settle();
    #2;
    model_eval();
    chk("cmd",     64'(proc2mem_command), 64'(m_cmd));
    chk("addr",    64'(proc2mem_addr),    64'(m_addr));
    chk("pdata",   proc2mem_data,         m_pdata);
    chk("dresp",   64'(dcache_response),  64'(m_dresp));
    chk("fill",    64'(fill_valid),       64'(m_fill));
    if (m_fill) chk("faddr", 64'(fill_addr), 64'(m_faddr));
    chk("pending", 64'(slot_pending),     64'(m_pend));
    chk("stall",   64'(miss_stall),       64'(m_stall));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    fetch_addr = '0; fetch_miss = '0; take_branch = 1'b0;
    dcache_command = BUS_NONE; dcache_addr = '0; dcache_data = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_clear();
    settle();
    chk("rst_cmd",   64'(proc2mem_command), 64'(BUS_NONE));
    chk("rst_fill",  64'(fill_valid),       64'd0);
    chk("rst_pend",  64'(slot_pending),     64'd0);
    chk("rst_stall", 64'(miss_stall),       64'd0);
    chk("rst_dresp", 64'(dcache_response),  64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a2, a1;
    logic [2:0]  miss;
    BUS_COMMAND  dcmd;
    logic [31:0] daddr;
    logic [3:0]  resp, tag;
    BUS_COMMAND  e_cmd;
    logic [31:0] e_addr;
    logic        e_fill;
    logic [31:0] e_faddr;
    logic [2:0]  e_pend;
    logic [3:0]  e_dresp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    idle_inputs();
    model_clear();

    // single miss, then merge of two slots in one block, then D-side pass-through
    tbl[0]  = '{32'h100, 32'h0,   3'b100, BUS_NONE,  32'h0,  4'd0, 4'd0, BUS_NONE,  32'h0,   1'b0, 32'h0,   3'b000, 4'd0};
    tbl[1]  = '{32'h100, 32'h0,   3'b000, BUS_NONE,  32'h0,  4'd3, 4'd0, BUS_LOAD,  32'h100, 1'b0, 32'h0,   3'b000, 4'd0};
    tbl[2]  = '{32'h0,   32'h0,   3'b000, BUS_NONE,  32'h0,  4'd0, 4'd0, BUS_NONE,  32'h0,   1'b0, 32'h0,   3'b000, 4'd0};
    tbl[3]  = '{32'h0,   32'h0,   3'b000, BUS_NONE,  32'h0,  4'd0, 4'd3, BUS_NONE,  32'h0,   1'b1, 32'h100, 3'b000, 4'd0};
    tbl[4]  = '{32'h0,   32'h0,   3'b000, BUS_NONE,  32'h0,  4'd0, 4'd3, BUS_NONE,  32'h0,   1'b0, 32'h0,   3'b000, 4'd0};
    tbl[5]  = '{32'h200, 32'h204, 3'b110, BUS_NONE,  32'h0,  4'd0, 4'd0, BUS_NONE,  32'h0,   1'b0, 32'h0,   3'b000, 4'd0};
    tbl[6]  = '{32'h200, 32'h204, 3'b110, BUS_NONE,  32'h0,  4'd0, 4'd0, BUS_LOAD,  32'h200, 1'b0, 32'h0,   3'b110, 4'd0};
    tbl[7]  = '{32'h0,   32'h0,   3'b000, BUS_NONE,  32'h0,  4'd4, 4'd0, BUS_LOAD,  32'h200, 1'b0, 32'h0,   3'b000, 4'd0};
    tbl[8]  = '{32'h0,   32'h0,   3'b000, BUS_NONE,  32'h0,  4'd0, 4'd0, BUS_NONE,  32'h0,   1'b0, 32'h0,   3'b000, 4'd0};
    tbl[9]  = '{32'h0,   32'h0,   3'b000, BUS_NONE,  32'h0,  4'd0, 4'd4, BUS_NONE,  32'h0,   1'b1, 32'h200, 3'b000, 4'd0};
    tbl[10] = '{32'h0,   32'h0,   3'b000, BUS_STORE, 32'h40, 4'd2, 4'd0, BUS_STORE, 32'h40,  1'b0, 32'h0,   3'b000, 4'd2};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      idle_inputs();
      fetch_addr[2] = tbl[i].a2; fetch_addr[1] = tbl[i].a1; fetch_miss = tbl[i].miss;
      dcache_command = tbl[i].dcmd; dcache_addr = tbl[i].daddr;
      mem2proc_response = tbl[i].resp; mem2proc_tag = tbl[i].tag;
      settle();
      chk($sformatf("v%0d_cmd", i),   64'(proc2mem_command), 64'(tbl[i].e_cmd));
      chk($sformatf("v%0d_addr", i),  64'(proc2mem_addr),    64'(tbl[i].e_addr));
      chk($sformatf("v%0d_fill", i),  64'(fill_valid),       64'(tbl[i].e_fill));
      if (tbl[i].e_fill) chk($sformatf("v%0d_faddr", i), 64'(fill_addr), 64'(tbl[i].e_faddr));
      chk($sformatf("v%0d_pend", i),  64'(slot_pending),     64'(tbl[i].e_pend));
      chk($sformatf("v%0d_dresp", i), 64'(dcache_response),  64'(tbl[i].e_dresp));
      tick();
    end

    // table full: four distinct blocks, responses withheld
    do_reset();
    for (int k = 0; k < 4; k++) begin
      idle_inputs(); fetch_addr[2] = 32'h400 + 32'(8*k); fetch_miss = 3'b100;
      settle(); tick();
    end
    idle_inputs(); fetch_addr[2] = 32'h440; fetch_miss = 3'b100;
    settle();
    chk("full_stall", 64'(miss_stall),   64'd1);
    chk("full_pend",  64'(slot_pending), 64'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      idle_inputs(); mem2proc_response = 4'(k + 1);
      settle();
      chk("full_issue", 64'(proc2mem_addr), 64'(32'h400 + 32'(8*k)));
      tick();
    end
    idle_inputs(); mem2proc_response = 4'd9;
    settle();
    chk("full_no5th", 64'(proc2mem_command), 64'(BUS_NONE));
    tick();

    // starvation: D-side busy every cycle, I-side wins on the 5th
    do_reset();
    idle_inputs(); fetch_addr[2] = 32'h600; fetch_miss = 3'b100;
    settle(); tick();
    for (int k = 1; k <= 5; k++) begin
      idle_inputs(); dcache_command = BUS_LOAD; dcache_addr = 32'h80; mem2proc_response = 4'd1;
      settle();
      chk($sformatf("starve%0d_addr", k),  64'(proc2mem_addr),   64'(k < 5 ? 32'h80 : 32'h600));
      chk($sformatf("starve%0d_dresp", k), 64'(dcache_response), 64'(k < 5 ? 4'd1 : 4'd0));
      tick();
    end

    // squash: two awaiting issue, one in flight with tag 5
    do_reset();
    idle_inputs(); fetch_addr[2] = 32'h300; fetch_miss = 3'b100; settle(); tick();
    idle_inputs(); fetch_addr[2] = 32'h308; fetch_miss = 3'b100; mem2proc_response = 4'd5; settle(); tick();
    idle_inputs(); fetch_addr[2] = 32'h310; fetch_miss = 3'b100; dcache_command = BUS_STORE; settle(); tick();
    idle_inputs(); take_branch = 1'b1; dcache_command = BUS_STORE; settle(); tick();
    idle_inputs(); fetch_addr[2] = 32'h308; fetch_addr[1] = 32'h300; fetch_miss = 3'b110;
    settle();
    chk("squash_cmd",  64'(proc2mem_command), 64'(BUS_NONE));
    chk("squash_pend", 64'(slot_pending),     64'b010);
    tick();
    idle_inputs(); dcache_command = BUS_STORE; mem2proc_tag = 4'd5;
    settle();
    chk("squash_fill",  64'(fill_valid), 64'd1);
    chk("squash_faddr", 64'(fill_addr),  64'h300);
    tick();

    // reset with tag 7 outstanding
    do_reset();
    idle_inputs(); fetch_addr[2] = 32'h500; fetch_miss = 3'b100; settle(); tick();
    idle_inputs(); mem2proc_response = 4'd7; settle(); tick();
    idle_inputs(); settle(); tick();
    do_reset();
    idle_inputs(); mem2proc_tag = 4'd7;
    settle();
    chk("rst_tag7", 64'(fill_valid), 64'd0);
    tick();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (c % 700 == 699) do_reset();
      idle_inputs();
      for (int s = 0; s < 3; s++)
        fetch_addr[s] = 32'h1000 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
      fetch_miss     = 3'($urandom_range(0, 7));
      take_branch    = ($urandom_range(0, 15) == 0);
      dcache_command = BUS_COMMAND'($urandom_range(0, 2));
      dcache_addr    = $urandom;
      dcache_data    = {$urandom, $urandom};
      mem2proc_data  = {$urandom, $urandom};
      mem2proc_response = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      begin
        int pick = $urandom_range(0, DEPTH);
        if (pick < DEPTH && st[pick] == 2 && $urandom_range(0, 1) == 1) mem2proc_tag = tg[pick];
        else mem2proc_tag = 4'($urandom_range(0, 15));
      end
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
